// File: rtl/prio_encoder_rr.sv
// Registered N-line priority encoder with a pending register and a valid/ready grant port.
// Selection is fixed (highest index wins) or round-robin, searching downward from the last grant.
module prio_encoder_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic         i_rr_mode,
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_out_idx,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_pending,
    output logic         o_overflow
);

    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_ptr;
    logic         r_valid;
    logic         r_overflow;

    logic [W-1:0] w_sel;
    logic [W-1:0] w_cand;
    logic         w_slotFree;
    logic         w_load;
    logic [N-1:0] w_clear;

    // Candidates are visited lowest-priority first so the last hit wins; the RR order
    // starts at (ptr-1) mod N and wraps below zero to N-1.
    always_comb begin
        w_sel  = '0;
        w_cand = '0;
        if (!i_rr_mode) begin
            for (int i = 0; i < N; i++) begin
                if (r_pending[i]) w_sel = W'(i);
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                w_cand = W'((int'(r_ptr) + 2 * N - 1 - k) % N);
                if (r_pending[w_cand]) w_sel = w_cand;
            end
        end
    end

    assign w_slotFree = !r_valid || i_out_ready;
    assign w_load     = i_enable && w_slotFree && (r_pending != '0);
    assign w_clear    = w_load ? (N'(1) << w_sel) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending  <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_idx   <= w_sel;
                r_ptr   <= w_sel;
                r_valid <= 1'b1;
            end else if (r_valid && i_out_ready) begin
                r_valid <= 1'b0;
            end
            // A request landing on the bit being granted re-arms it rather than colliding.
            if (i_enable) begin
                r_pending <= (r_pending & ~w_clear) | i_req;
            end
            r_overflow <= i_enable && |(i_req & r_pending & ~w_clear);
        end
    end

    assign o_out_idx   = r_idx;
    assign o_out_valid = r_valid;
    assign o_pending   = r_pending;
    assign o_overflow  = r_overflow;

endmodule
